// File: rtl/sg_norm_ctrl.sv
// Multi-cycle normalization controller for the half-precision MAC significand
// product. Takes a 2.20 product plus exponent sum. Finds the leading one, then
// shifts left in SHIFT_STEP chunks until it reaches bit 21. Packs a 5-bit
// exponent and a 10-bit truncated fraction, with zero/overflow/underflow flags.
module sg_norm_ctrl #(
  parameter int SHIFT_STEP = 4,
  parameter int EXP_MAX    = 30
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [6:0]  in_exp,
  input  logic [21:0] in_sig,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [4:0]  out_exp,
  output logic [9:0]  out_frac,
  output logic        out_zero,
  output logic        out_ovf,
  output logic        out_udf,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_DETECT, S_SHIFT, S_PACK, S_DONE} state_t;

  localparam logic [4:0]        STEP  = 5'(SHIFT_STEP);
  localparam logic signed [7:0] EMAX8 = 8'(EXP_MAX);

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [6:0]  exp_q, exp_d;
  logic [21:0] sig_q, sig_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rem_q, rem_d;
  logic        out_sign_q, out_sign_d;
  logic [4:0]  out_exp_q, out_exp_d;
  logic [9:0]  out_frac_q, out_frac_d;
  logic        out_zero_q, out_zero_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_udf_q, out_udf_d;

  logic [4:0]  lead;
  logic [4:0]  step;
  logic [7:0]  e_val;

  // Index of the highest set bit; an all-zero value reports 21 so the shift is 0.
  function automatic logic [4:0] lead_one(input logic [21:0] v);
    logic [4:0] r;
    r = 5'd21;
    for (int i = 0; i < 22; i++)
      if (v[i]) r = 5'(i);
    return r;
  endfunction

  // Next-state and datapath: each state owns the registers it updates.
  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    sig_d      = sig_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    out_sign_d = out_sign_q;
    out_exp_d  = out_exp_q;
    out_frac_d = out_frac_q;
    out_zero_d = out_zero_q;
    out_ovf_d  = out_ovf_q;
    out_udf_d  = out_udf_q;
    lead       = lead_one(sig_q);
    step       = (rem_q < STEP) ? rem_q : STEP;
    // Total shift is recovered from cnt_q, which stays fixed while sig_q moves.
    e_val      = {exp_q[6], exp_q} + 8'd1 - {3'd0, 5'd21 - cnt_q};
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        sign_d  = in_sign;
        exp_d   = in_exp;
        sig_d   = in_sig;
        state_d = S_DETECT;
      end
      S_DETECT: begin
        cnt_d   = lead;
        rem_d   = 5'd21 - lead;
        state_d = (lead != 5'd21) ? S_SHIFT : S_PACK;
      end
      S_SHIFT: begin
        sig_d = sig_q << step;
        rem_d = rem_q - step;
        if (rem_q == step) state_d = S_PACK;
      end
      S_PACK: begin
        out_sign_d = sign_q;
        out_exp_d  = e_val[4:0];
        out_frac_d = sig_q[20:11];
        out_zero_d = 1'b0;
        out_ovf_d  = 1'b0;
        out_udf_d  = 1'b0;
        if (sig_q == 22'd0) begin
          out_exp_d  = 5'd0;
          out_frac_d = 10'd0;
          out_zero_d = 1'b1;
        end else if ($signed(e_val) > EMAX8) begin
          out_exp_d  = 5'd31;
          out_frac_d = 10'd0;
          out_ovf_d  = 1'b1;
        end else if ($signed(e_val) < 8'sd1) begin
          out_exp_d  = 5'd0;
          out_frac_d = 10'd0;
          out_udf_d  = 1'b1;
        end
        state_d = S_DONE;
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and data registers; reset aborts any operation in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      sig_q      <= '0;
      cnt_q      <= 5'd21;
      rem_q      <= '0;
      out_sign_q <= 1'b0;
      out_exp_q  <= '0;
      out_frac_q <= '0;
      out_zero_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_udf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      sig_q      <= sig_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      out_sign_q <= out_sign_d;
      out_exp_q  <= out_exp_d;
      out_frac_q <= out_frac_d;
      out_zero_q <= out_zero_d;
      out_ovf_q  <= out_ovf_d;
      out_udf_q  <= out_udf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_sign  = out_sign_q;
  assign out_exp   = out_exp_q;
  assign out_frac  = out_frac_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;
  assign out_udf   = out_udf_q;

endmodule

// File: tb/tb_sg_norm_ctrl.sv
// Self-checking bench for sg_norm_ctrl: directed cases, random operands against
// a reference model, backpressure and mid-operation reset.
module tb_sg_norm_ctrl;
  localparam int STEP = 4;
  localparam int EMAX = 30;

  logic        clock, resetn;
  logic        in_valid, in_ready, in_sign;
  logic [6:0]  in_exp;
  logic [21:0] in_sig;
  logic        out_valid, out_ready, out_sign;
  logic [4:0]  out_exp;
  logic [9:0]  out_frac;
  logic        out_zero, out_ovf, out_udf, busy;

  int checks = 0;
  int errors = 0;

  sg_norm_ctrl #(.SHIFT_STEP(STEP), .EXP_MAX(EMAX)) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_exp(in_exp), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_frac(out_frac),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_udf(out_udf), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] obs();
    return {out_sign, out_exp, out_frac, out_zero, out_ovf, out_udf};
  endfunction

  // Reference: normalize by repeated doubling, then apply the exponent rules.
  task automatic model(input logic sign, input logic [6:0] exp, input logic [21:0] sig,
                       output logic [18:0] vec, output int lat);
    logic [21:0] v;
    int s, e;
    v = sig;
    s = 0;
    if (sig != 0)
      while (v[21] == 1'b0) begin
        v = v << 1;
        s++;
      end
    e = int'($signed(exp)) + 1 - s;
    lat = 2 + (s + STEP - 1) / STEP;
    if (sig == 0)      vec = {sign, 5'd0, 10'd0, 3'b100};
    else if (e > EMAX) vec = {sign, 5'd31, 10'd0, 3'b010};
    else if (e < 1)    vec = {sign, 5'd0, 10'd0, 3'b001};
    else               vec = {sign, 5'(e), v[20:11], 3'b000};
  endtask

  // Presents one operand, returns edges from accept to out_valid (40 = timed out).
  // Leaves the DUT waiting in DONE with out_ready low.
  task automatic run_op(input logic sign, input logic [6:0] exp, input logic [21:0] sig,
                        output int lat);
    in_sign  = sign;
    in_exp   = exp;
    in_sig   = sig;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 100", {in_ready, busy, out_valid});
    end
    checks++;
    if (obs() !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", obs());
    end
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [6:0]  te [6] = '{7'd15, 7'd15, 7'd30, 7'd20, 7'd30, 7'd5};
    logic [21:0] ts [6] = '{22'h200000, 22'h180000, 22'h000001, 22'h0, 22'h3FF800, 22'h000001};
    logic        tg [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int          tl [6] = '{2, 3, 8, 2, 2, 8};
    logic [18:0] tv [6] = '{{1'b0, 5'd16, 10'h000, 3'b000},
                            {1'b1, 5'd15, 10'h200, 3'b000},
                            {1'b0, 5'd10, 10'h000, 3'b000},
                            {1'b1, 5'd0,  10'h000, 3'b100},
                            {1'b0, 5'd31, 10'h000, 3'b010},
                            {1'b1, 5'd0,  10'h000, 3'b001}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(tg[i], te[i], ts[i], lat);
      checks++;
      if (lat !== tl[i]) begin
        errors++;
        $display("FAIL directed%0d_latency got %0d want %0d", i, lat, tl[i]);
      end
      checks++;
      if (obs() !== tv[i]) begin
        errors++;
        $display("FAIL directed%0d_result got %h want %h", i, obs(), tv[i]);
      end
      handshake();
    end
  endtask

  task automatic test_random();
    logic [18:0] ev;
    logic [21:0] sig;
    logic [6:0]  exp;
    logic        sign;
    int el, lat;
    for (int i = 0; i < 60; i++) begin
      sign = 1'($urandom);
      exp  = 7'($urandom);
      sig  = 22'($urandom) >> $urandom_range(0, 22);
      if ($urandom_range(0, 9) == 0) sig = 22'd0;
      model(sign, exp, sig, ev, el);
      run_op(sign, exp, sig, lat);
      checks++;
      if (lat !== el || obs() !== ev) begin
        errors++;
        $display("FAIL random%0d sig=%h exp=%h got lat %0d res %h want lat %0d res %h",
                 i, sig, exp, lat, obs(), el, ev);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    logic [18:0] ev2, ev1;
    int el, lat;
    model(1'b1, 7'd15, 22'h180000, ev2, el);
    run_op(1'b1, 7'd15, 22'h180000, lat);
    for (int c = 0; c < 5; c++) begin
      // A stray operand while DONE must not be taken.
      in_valid = (c == 2);
      in_sig   = 22'h000001;
      in_exp   = 7'd5;
      in_sign  = 1'b0;
      @(posedge clock); #1;
      in_valid = 1'b0;
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || obs() !== ev2) begin
        errors++;
        $display("FAIL hold%0d got v/r %b res %h want 10 res %h", c, {out_valid, in_ready}, obs(), ev2);
      end
    end
    handshake();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL release got %b want 010", {out_valid, in_ready, busy});
    end
    model(1'b0, 7'd15, 22'h200000, ev1, el);
    run_op(1'b0, 7'd15, 22'h200000, lat);
    checks++;
    if (lat !== el || obs() !== ev1) begin
      errors++;
      $display("FAIL b2b got lat %0d res %h want lat %0d res %h", lat, obs(), el, ev1);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat;
    in_sign = 1'b0; in_exp = 7'd30; in_sig = 22'h000001; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({busy, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midshift_busy got %b want 10", {busy, out_valid});
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || obs() !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got ctrl %b res %h want 100 res 0", {in_ready, busy, out_valid}, obs());
    end
    @(posedge clock); #1;
    resetn = 1'b1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_idle got busy %b want 0", busy);
    end
    run_op(1'b0, 7'd15, 22'h200000, lat);
    checks++;
    if (lat !== 2 || obs() !== {1'b0, 5'd16, 10'h000, 3'b000}) begin
      errors++;
      $display("FAIL after_reset got lat %0d res %h want lat 2 res %h", lat, obs(),
               {1'b0, 5'd16, 10'h000, 3'b000});
    end
    handshake();
  endtask

  initial begin
    in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_sig = '0; out_ready = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
